bias_ctrl_seq: RTL and testbench
================================

BIAS_CTRL_SEQ -- requirements
Module: bias_ctrl_seq

Interface
REQ-001 Parameter STARTUP_CYC, default 16: cycles BG_STARTUP_O is held high after enable.
REQ-002 Parameter SETTLE_CYC, default 64: cycles waited after startup release before valid is sampled.
REQ-003 Parameter TIMEOUT_CYC, default 1024: maximum cycles in WAIT_VALID before fault.
REQ-004 Parameters TRIM_BIAS_RST (4'd8), TRIM_CURV_RST (5'd16), TRIM_VBG_RST (5'd16): trim reset values.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-006 CLK_I  in  1  block clock, rising edge.
REQ-007 RST_I  in  1  asynchronous active-high reset.
REQ-008 ENABLE_REQ_I  in  1  level request to power up the bias generator.
REQ-009 VBIAS_REQ_I  in  1  level request to drive VBIAS once ready.
REQ-010 TRIM_VALID_I / TRIM_READY_O  in/out  1/1  trim update handshake.
REQ-011 TRIM_DATA_I  in  14  {VBG[13:9], CURV[8:4], BIAS[3:0]}.
REQ-012 BG_VALID_N_I  in  1  asynchronous active-low valid from bias cell.
REQ-013 EN_O, BG_STARTUP_O, EN_VBIAS_O  out  1 each  bias cell controls.
REQ-014 TRIM_BIAS_O[3:0], TRIM_CURV_O[4:0], TRIM_VBG_O[4:0]  out  registered trim to bias cell.
REQ-015 READY_O, FAULT_O  out  1 each  status; STATE_O  out  3  current state encoding.

Function
REQ-016 States and encodings SHALL be OFF=0, STARTUP=1, SETTLE=2, WAIT_VALID=3, READY=4, FAULT=5; all outputs registered.
REQ-017 BG_VALID_N_I SHALL pass a 2-flop synchronizer (reset value 1); all FSM decisions use the synchronized value.
REQ-018 OFF: EN_O=0, BG_STARTUP_O=0; ENABLE_REQ_I=1 -> STARTUP next cycle.
REQ-019 STARTUP: EN_O=1, BG_STARTUP_O=1 for exactly STARTUP_CYC cycles, then -> SETTLE.
REQ-020 SETTLE: EN_O=1, BG_STARTUP_O=0 for exactly SETTLE_CYC cycles, then -> WAIT_VALID.
REQ-021 WAIT_VALID: synchronized valid_n=0 -> READY; TIMEOUT_CYC cycles without it -> FAULT.
REQ-022 READY: READY_O=1; synchronized valid_n=1 -> FAULT.
REQ-023 EN_VBIAS_O SHALL equal 1 only while in READY and VBIAS_REQ_I=1 (one cycle registered latency); 0 in all other states.
REQ-024 FAULT: EN_O=0, BG_STARTUP_O=0, EN_VBIAS_O=0, FAULT_O=1 sticky; exits to OFF only when ENABLE_REQ_I=0, clearing FAULT_O.
REQ-025 ENABLE_REQ_I=0 in any state SHALL force OFF next cycle and clear all counters.
REQ-026 TRIM_READY_O SHALL be 1 only in OFF and READY; transfer when TRIM_VALID_I and TRIM_READY_O both 1; trim outputs update next cycle.
REQ-027 Trim transfer in READY SHALL move to SETTLE (no startup pulse), dropping READY_O and EN_VBIAS_O next cycle.
REQ-028 Priority in one cycle: ENABLE_REQ_I=0 > fault condition > trim transfer > normal transition; a trim transfer accepted in the fault cycle still updates the trim outputs.
REQ-029 Counters SHALL be sized for the largest parameter, never wrap, and reset on every state change.

Reset
REQ-030 On RST_I=1, immediately: state OFF, EN_O=0, BG_STARTUP_O=0, EN_VBIAS_O=0, READY_O=0, FAULT_O=0, synchronizer=1, trims = reset parameters, counters 0.
REQ-031 Reset asserted mid-sequence SHALL abort identically; after release the block waits in OFF until ENABLE_REQ_I is sampled high.

Verification
REQ-032 Power-up: ENABLE_REQ_I=1 at cycle 0, cell model valid_n=!(EN_O&&!BG_STARTUP_O) -> BG_STARTUP_O high cycles 1-16, STATE_O=3 at cycle 81, READY_O=1 at cycle 82.
REQ-033 Timeout: BG_VALID_N_I held 1 -> STATE_O=5, FAULT_O=1 at cycle 1105, EN_O=0; ENABLE_REQ_I=0 -> STATE_O=0, FAULT_O=0 next cycle.
REQ-034 Valid loss: in READY with VBIAS_REQ_I=1, force BG_VALID_N_I=1 -> FAULT within 3 cycles, EN_VBIAS_O=0.
REQ-035 Trim update in READY: TRIM_DATA_I=14'h1A35 accepted -> TRIM_VBG_O=5'd13, TRIM_CURV_O=5'd3, TRIM_BIAS_O=4'd5, READY_O=0 for >=64 cycles, then READY again.
REQ-036 Abort: ENABLE_REQ_I dropped at cycle 10 (STARTUP) -> STATE_O=0, BG_STARTUP_O=0 at cycle 11; RST_I pulse in SETTLE -> all outputs at reset values asynchronously.
REQ-037 Handshake: TRIM_VALID_I=1 during STARTUP -> TRIM_READY_O=0, trims unchanged until READY.

Source files
------------

// File: rtl/bias_ctrl_seq_if.sv
// bias_ctrl_seq_if: control/status bundle between a bias-cell sequencer and its host/bias cell.
// Signals are named from the sequencer's point of view:
//   enable_req_i, vbias_req_i     host power-up and VBIAS drive requests (levels)
//   trim_valid_i, trim_data_i     trim update offer {VBG[13:9], CURV[8:4], BIAS[3:0]}
//   trim_ready_o                  trim update acceptance
//   bg_valid_n_i                  asynchronous active-low valid from the bias cell
//   en_o, bg_startup_o, en_vbias_o        bias cell controls
//   trim_bias_o, trim_curv_o, trim_vbg_o  registered trims to the bias cell
//   ready_o, fault_o, state_o             status
interface bias_ctrl_seq_if;
    logic        enable_req_i;
    logic        vbias_req_i;
    logic        trim_valid_i;
    logic        trim_ready_o;
    logic [13:0] trim_data_i;
    logic        bg_valid_n_i;
    logic        en_o;
    logic        bg_startup_o;
    logic        en_vbias_o;
    logic [3:0]  trim_bias_o;
    logic [4:0]  trim_curv_o;
    logic [4:0]  trim_vbg_o;
    logic        ready_o;
    logic        fault_o;
    logic [2:0]  state_o;
    modport slave (
        input  enable_req_i, vbias_req_i, trim_valid_i, trim_data_i, bg_valid_n_i,
        output trim_ready_o, en_o, bg_startup_o, en_vbias_o, trim_bias_o, trim_curv_o,
               trim_vbg_o, ready_o, fault_o, state_o
    );
    modport master (
        output enable_req_i, vbias_req_i, trim_valid_i, trim_data_i, bg_valid_n_i,
        input  trim_ready_o, en_o, bg_startup_o, en_vbias_o, trim_bias_o, trim_curv_o,
               trim_vbg_o, ready_o, fault_o, state_o
    );
endinterface

// File: rtl/bias_ctrl_seq.sv
// bias_ctrl_seq: power-up / settle / valid-monitor sequencer for a bandgap bias cell with trim loading.
// Ports: clk_i (rising edge), rst_i (async active-high), bus (bias_ctrl_seq_if.slave: requests,
// trim handshake, bias cell valid in; cell controls, trims, ready/fault/state out; all outputs registered).
module bias_ctrl_seq #(
    parameter int unsigned STARTUP_CYC   = 16,
    parameter int unsigned SETTLE_CYC    = 64,
    parameter int unsigned TIMEOUT_CYC   = 1024,
    parameter logic [3:0]  TRIM_BIAS_RST = 4'd8,
    parameter logic [4:0]  TRIM_CURV_RST = 5'd16,
    parameter logic [4:0]  TRIM_VBG_RST  = 5'd16
) (
    input logic             clk_i,
    input logic             rst_i,
    bias_ctrl_seq_if.slave  bus
);
    localparam int unsigned MAX_AB  = STARTUP_CYC > SETTLE_CYC ? STARTUP_CYC : SETTLE_CYC;
    localparam int unsigned MAX_CYC = MAX_AB > TIMEOUT_CYC ? MAX_AB : TIMEOUT_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    typedef enum logic [2:0] {
        S_OFF = 3'd0, S_STARTUP = 3'd1, S_SETTLE = 3'd2,
        S_WAIT_VALID = 3'd3, S_READY = 3'd4, S_FAULT = 3'd5
    } state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vn_meta_q, vn_sync_q;
    logic [13:0]   trim_q;
    logic          en_q, startup_q, vbias_q, ready_q, fault_q, trim_ready_q;
    logic          xfer;
    assign xfer = bus.trim_valid_i && trim_ready_q;
    // Fault checks precede the trim transfer in READY; enable drop overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OFF:        state_d = bus.enable_req_i ? S_STARTUP : S_OFF;
            S_STARTUP:    state_d = cnt_q == CW'(STARTUP_CYC - 1) ? S_SETTLE : S_STARTUP;
            S_SETTLE:     state_d = cnt_q == CW'(SETTLE_CYC - 1) ? S_WAIT_VALID : S_SETTLE;
            S_WAIT_VALID: state_d = !vn_sync_q ? S_READY :
                                    cnt_q == CW'(TIMEOUT_CYC - 1) ? S_FAULT : S_WAIT_VALID;
            S_READY:      state_d = vn_sync_q ? S_FAULT : xfer ? S_SETTLE : S_READY;
            S_FAULT:      state_d = S_FAULT;
            default:      state_d = S_OFF;
        endcase
        if (!bus.enable_req_i) state_d = S_OFF;
        // Only timed states count, so the counter can never run past its limit.
        cnt_d = (state_d != state_q || !(state_q inside {S_STARTUP, S_SETTLE, S_WAIT_VALID}))
                ? '0 : cnt_q + 1'b1;
    end
    // Outputs are registered from the next state so they line up with STATE_O.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            vn_meta_q    <= 1'b1;
            vn_sync_q    <= 1'b1;
            trim_q       <= {TRIM_VBG_RST, TRIM_CURV_RST, TRIM_BIAS_RST};
            en_q         <= 1'b0;
            startup_q    <= 1'b0;
            vbias_q      <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            trim_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vn_meta_q    <= bus.bg_valid_n_i;
            vn_sync_q    <= vn_meta_q;
            if (xfer) trim_q <= bus.trim_data_i;
            en_q         <= state_d inside {S_STARTUP, S_SETTLE, S_WAIT_VALID, S_READY};
            startup_q    <= state_d == S_STARTUP;
            vbias_q      <= state_d == S_READY && bus.vbias_req_i;
            ready_q      <= state_d == S_READY;
            fault_q      <= state_d == S_FAULT;
            trim_ready_q <= state_d inside {S_OFF, S_READY};
        end
    end
    assign bus.state_o      = state_q;
    assign bus.en_o         = en_q;
    assign bus.bg_startup_o = startup_q;
    assign bus.en_vbias_o   = vbias_q;
    assign bus.ready_o      = ready_q;
    assign bus.fault_o      = fault_q;
    assign bus.trim_ready_o = trim_ready_q;
    assign bus.trim_vbg_o   = trim_q[13:9];
    assign bus.trim_curv_o  = trim_q[8:4];
    assign bus.trim_bias_o  = trim_q[3:0];
endmodule

// File: tb/tb_bias_ctrl_seq.sv
// tb_bias_ctrl_seq: directed bench for bias_ctrl_seq with a simple bias cell valid model.
module tb_bias_ctrl_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vn_force = 1'b0;
    int   total = 0;
    int   bad = 0;
    bias_ctrl_seq_if bif ();
    bias_ctrl_seq dut (.clk_i(clk), .rst_i(rst), .bus(bif.slave));
    always #5 clk = ~clk;
    // Cell reports valid once enabled and out of startup, unless forced invalid.
    assign bif.bg_valid_n_i = vn_force | !(bif.en_o && !bif.bg_startup_o);
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic chk_trim(input string tag, input logic [4:0] vbg, input logic [4:0] curv,
                            input logic [3:0] bias);
        chk({tag, "_vbg"}, 32'(bif.trim_vbg_o), 32'(vbg));
        chk({tag, "_curv"}, 32'(bif.trim_curv_o), 32'(curv));
        chk({tag, "_bias"}, 32'(bif.trim_bias_o), 32'(bias));
    endtask
    initial begin
        bif.enable_req_i = 1'b0;
        bif.vbias_req_i  = 1'b0;
        bif.trim_valid_i = 1'b0;
        bif.trim_data_i  = '0;
        step(2);
        chk("rst_state", 32'(bif.state_o), 0);
        chk("rst_en", 32'(bif.en_o), 0);
        chk("rst_ready", 32'(bif.ready_o), 0);
        chk("rst_fault", 32'(bif.fault_o), 0);
        chk_trim("rst_trim", 5'd16, 5'd16, 4'd8);
        rst = 1'b0;
        step(2);
        chk("idle_state", 32'(bif.state_o), 0);
        chk("idle_trdy", 32'(bif.trim_ready_o), 1);
        // power-up: enable at cycle 0
        bif.enable_req_i = 1'b1;
        step(1);
        chk("pu_c1_state", 32'(bif.state_o), 1);
        chk("pu_c1_start", 32'(bif.bg_startup_o), 1);
        chk("pu_c1_en", 32'(bif.en_o), 1);
        step(15);
        chk("pu_c16_start", 32'(bif.bg_startup_o), 1);
        step(1);
        chk("pu_c17_start", 32'(bif.bg_startup_o), 0);
        chk("pu_c17_state", 32'(bif.state_o), 2);
        step(63);
        chk("pu_c80_state", 32'(bif.state_o), 2);
        step(1);
        chk("pu_c81_state", 32'(bif.state_o), 3);
        step(1);
        chk("pu_c82_ready", 32'(bif.ready_o), 1);
        chk("pu_c82_state", 32'(bif.state_o), 4);
        chk("pu_c82_vbias", 32'(bif.en_vbias_o), 0);
        bif.vbias_req_i = 1'b1;
        step(1);
        chk("vbias_on", 32'(bif.en_vbias_o), 1);
        // trim update in READY
        bif.trim_valid_i = 1'b1;
        bif.trim_data_i  = 14'h1A35;
        step(1);
        bif.trim_valid_i = 1'b0;
        chk_trim("trim1", 5'd13, 5'd3, 4'd5);
        chk("trim1_ready", 32'(bif.ready_o), 0);
        chk("trim1_vbias", 32'(bif.en_vbias_o), 0);
        chk("trim1_state", 32'(bif.state_o), 2);
        chk("trim1_start", 32'(bif.bg_startup_o), 0);
        step(63);
        chk("trim1_t63_ready", 32'(bif.ready_o), 0);
        step(2);
        chk("trim1_t65_ready", 32'(bif.ready_o), 1);
        chk("trim1_t65_vbias", 32'(bif.en_vbias_o), 1);
        // valid loss in READY
        vn_force = 1'b1;
        step(3);
        chk("loss_state", 32'(bif.state_o), 5);
        chk("loss_fault", 32'(bif.fault_o), 1);
        chk("loss_vbias", 32'(bif.en_vbias_o), 0);
        chk("loss_en", 32'(bif.en_o), 0);
        chk("loss_trdy", 32'(bif.trim_ready_o), 0);
        step(2);
        chk("loss_sticky", 32'(bif.fault_o), 1);
        bif.enable_req_i = 1'b0;
        bif.vbias_req_i  = 1'b0;
        step(1);
        chk("loss_clr_state", 32'(bif.state_o), 0);
        chk("loss_clr_fault", 32'(bif.fault_o), 0);
        // timeout with the cell never valid
        bif.enable_req_i = 1'b1;
        step(81);
        chk("to_c81_state", 32'(bif.state_o), 3);
        step(1023);
        chk("to_c1104_state", 32'(bif.state_o), 3);
        step(1);
        chk("to_c1105_state", 32'(bif.state_o), 5);
        chk("to_c1105_fault", 32'(bif.fault_o), 1);
        chk("to_c1105_en", 32'(bif.en_o), 0);
        bif.enable_req_i = 1'b0;
        step(1);
        chk("to_clr_state", 32'(bif.state_o), 0);
        chk("to_clr_fault", 32'(bif.fault_o), 0);
        // trim offered during STARTUP is held off until READY
        vn_force = 1'b0;
        bif.enable_req_i = 1'b1;
        step(2);
        bif.trim_valid_i = 1'b1;
        bif.trim_data_i  = 14'h0ABC;
        step(1);
        chk("hs_c3_trdy", 32'(bif.trim_ready_o), 0);
        chk_trim("hs_c3", 5'd13, 5'd3, 4'd5);
        step(79);
        chk("hs_c82_ready", 32'(bif.ready_o), 1);
        chk("hs_c82_trdy", 32'(bif.trim_ready_o), 1);
        chk_trim("hs_c82", 5'd13, 5'd3, 4'd5);
        step(1);
        bif.trim_valid_i = 1'b0;
        chk_trim("hs_c83", 5'd5, 5'd11, 4'd12);
        chk("hs_c83_state", 32'(bif.state_o), 2);
        bif.enable_req_i = 1'b0;
        step(1);
        chk("hs_off", 32'(bif.state_o), 0);
        // enable dropped during STARTUP
        bif.enable_req_i = 1'b1;
        step(10);
        chk("ab_c10_state", 32'(bif.state_o), 1);
        bif.enable_req_i = 1'b0;
        step(1);
        chk("ab_c11_state", 32'(bif.state_o), 0);
        chk("ab_c11_start", 32'(bif.bg_startup_o), 0);
        // reset pulse in SETTLE acts without a clock edge
        bif.enable_req_i = 1'b1;
        step(20);
        chk("rs_settle", 32'(bif.state_o), 2);
        rst = 1'b1;
        #2;
        chk("rs_state", 32'(bif.state_o), 0);
        chk("rs_en", 32'(bif.en_o), 0);
        chk("rs_ready", 32'(bif.ready_o), 0);
        chk_trim("rs_trim", 5'd16, 5'd16, 4'd8);
        bif.enable_req_i = 1'b0;
        step(1);
        rst = 1'b0;
        step(3);
        chk("rs_wait_off", 32'(bif.state_o), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
